// File: rtl/fetch_decode_if.sv
// rtl/fetch_decode_if.sv - control inputs and decoded-instruction outputs of the fetch/decode stage
interface fetch_decode_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_pc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;

    modport master (
        input  stall, redirect, redirect_pc,
        output fetch_pc, pc, instr, valid, rs1, rs2, rd, opcode, funct3, funct7, imm
    );

    modport slave (
        output stall, redirect, redirect_pc,
        input  fetch_pc, pc, instr, valid, rs1, rs2, rd, opcode, funct3, funct7, imm
    );
endinterface

// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - PC, instruction memory, decode register and field/immediate split
module fetch_decode #(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    fetch_decode_if.master    bus
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   inst_mem [0:MEM_WORDS-1];
    logic [AW-1:0] mem_index;
    logic          unused_redirect_bits;

    // Upper address bits fall away here, so fetch wraps modulo the memory size.
    assign mem_index            = bus.fetch_pc[AW+1:2];
    assign unused_redirect_bits = ^bus.redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.fetch_pc <= RESET_PC;
            bus.pc       <= RESET_PC;
            bus.instr    <= NOP_INSTR;
            bus.valid    <= 1'b0;
        end else if (bus.redirect) begin
            bus.fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            bus.instr    <= NOP_INSTR;
            bus.valid    <= 1'b0;
        end else if (!bus.stall) begin
            bus.instr    <= inst_mem[mem_index];
            bus.pc       <= bus.fetch_pc;
            bus.valid    <= 1'b1;
            bus.fetch_pc <= bus.fetch_pc + 32'd4;
        end
    end

    assign bus.rs1    = bus.instr[19:15];
    assign bus.rs2    = bus.instr[24:20];
    assign bus.rd     = bus.instr[11:7];
    assign bus.opcode = bus.instr[6:0];
    assign bus.funct3 = bus.instr[14:12];
    assign bus.funct7 = bus.instr[31:25];

    always_comb begin
        bus.imm = 32'd0;
        unique case (bus.instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                bus.imm = {{20{bus.instr[31]}}, bus.instr[31:20]};
            7'b0100011:
                bus.imm = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
            7'b1100011:
                bus.imm = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                           bus.instr[30:25], bus.instr[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                bus.imm = {bus.instr[31:12], 12'd0};
            7'b1101111:
                bus.imm = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                           bus.instr[20], bus.instr[30:21], 1'b0};
            default:
                bus.imm = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_fetch_decode.sv
// tb/tb_fetch_decode.sv - directed self-checking bench for fetch_decode
module tb_fetch_decode;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    fetch_decode_if bus ();

    fetch_decode #(
        .MEM_WORDS (256),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        dut.inst_mem[0]   = 32'h0020_81B3;
        dut.inst_mem[1]   = 32'hFFF0_8293;
        dut.inst_mem[2]   = 32'h0020_A423;
        dut.inst_mem[3]   = 32'h1234_5237;
        dut.inst_mem[4]   = 32'h0010_0093;
        dut.inst_mem[5]   = 32'h0080_00EF;
        dut.inst_mem[255] = 32'hFE00_0EE3;

        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'd0;

        step();
        chk("rst_fetch_pc", bus.fetch_pc, 32'h0);
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_instr", bus.instr, 32'h13);
        chk("rst_rs1", {27'd0, bus.rs1}, 32'd0);
        chk("rst_rs2", {27'd0, bus.rs2}, 32'd0);
        chk("rst_rd", {27'd0, bus.rd}, 32'd0);
        chk("rst_imm", bus.imm, 32'd0);
        chk("rst_opcode", {25'd0, bus.opcode}, 32'h13);
        rst = 1'b0;

        step();
        chk("m0_valid", {31'd0, bus.valid}, 32'd1);
        chk("m0_pc", bus.pc, 32'h0);
        chk("m0_rs1", {27'd0, bus.rs1}, 32'd1);
        chk("m0_rs2", {27'd0, bus.rs2}, 32'd2);
        chk("m0_rd", {27'd0, bus.rd}, 32'd3);
        chk("m0_opcode", {25'd0, bus.opcode}, 32'h33);
        chk("m0_imm_rtype", bus.imm, 32'd0);
        chk("m0_fetch_pc", bus.fetch_pc, 32'h4);

        step();
        chk("m1_rd", {27'd0, bus.rd}, 32'd5);
        chk("m1_rs1", {27'd0, bus.rs1}, 32'd1);
        chk("m1_imm_i", bus.imm, 32'hFFFF_FFFF);
        chk("m1_pc", bus.pc, 32'h4);

        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", bus.pc, 32'h4);
            chk("stall_instr", bus.instr, 32'hFFF0_8293);
            chk("stall_fetch_pc", bus.fetch_pc, 32'h8);
            chk("stall_valid", {31'd0, bus.valid}, 32'd1);
        end
        bus.stall = 1'b0;

        step();
        chk("m2_pc", bus.pc, 32'h8);
        chk("m2_rs1", {27'd0, bus.rs1}, 32'd1);
        chk("m2_rs2", {27'd0, bus.rs2}, 32'd2);
        chk("m2_imm_s", bus.imm, 32'h8);

        step();
        chk("m3_rd", {27'd0, bus.rd}, 32'd4);
        chk("m3_imm_u", bus.imm, 32'h1234_5000);
        chk("m3_fetch_pc", bus.fetch_pc, 32'h10);

        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0013;
        bus.stall = 1'b1;
        step();
        chk("redir_fetch_pc", bus.fetch_pc, 32'h10);
        chk("redir_valid", {31'd0, bus.valid}, 32'd0);
        chk("redir_rd", {27'd0, bus.rd}, 32'd0);
        chk("redir_pc_hold", bus.pc, 32'hC);
        bus.redirect = 1'b0;
        bus.stall = 1'b0;

        step();
        chk("redir_next_pc", bus.pc, 32'h10);
        chk("redir_next_valid", {31'd0, bus.valid}, 32'd1);
        chk("redir_next_instr", bus.instr, 32'h0010_0093);
        chk("m4_imm_i", bus.imm, 32'h1);

        step();
        chk("m5_pc", bus.pc, 32'h14);
        chk("m5_rd", {27'd0, bus.rd}, 32'd1);
        chk("m5_imm_j", bus.imm, 32'h8);

        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_03FC;
        step();
        chk("wrap_fetch_pc", bus.fetch_pc, 32'h3FC);
        bus.redirect = 1'b0;
        step();
        chk("wrap_last_pc", bus.pc, 32'h3FC);
        chk("wrap_last_instr", bus.instr, 32'hFE00_0EE3);
        chk("m255_imm_b", bus.imm, 32'hFFFF_FFFC);
        step();
        chk("wrap_instr", bus.instr, 32'h0020_81B3);
        chk("wrap_pc", bus.pc, 32'h400);
        chk("wrap_fetch_pc2", bus.fetch_pc, 32'h404);

        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFE;
        step();
        chk("top_fetch_pc", bus.fetch_pc, 32'hFFFF_FFFC);
        bus.redirect = 1'b0;
        step();
        chk("top_wrap_fetch_pc", bus.fetch_pc, 32'h0);
        chk("top_pc", bus.pc, 32'hFFFF_FFFC);
        chk("top_instr", bus.instr, 32'hFE00_0EE3);

        bus.stall = 1'b1;
        rst = 1'b1;
        step();
        chk("midrst_valid", {31'd0, bus.valid}, 32'd0);
        chk("midrst_fetch_pc", bus.fetch_pc, 32'h0);
        chk("midrst_pc", bus.pc, 32'h0);
        chk("midrst_instr", bus.instr, 32'h13);
        rst = 1'b0;
        bus.stall = 1'b0;
        step();
        chk("post_rst_instr", bus.instr, 32'h0020_81B3);
        chk("post_rst_fetch_pc", bus.fetch_pc, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
Front-end stage of the single-issue RISC-V core. Holds the program counter and an on-chip instruction memory, and registers one fetched instruction per clock. Combinationally splits that instruction into register-file addresses (rs1, rs2, rd), control fields and a sign-extended immediate. Feeds the register file and the execute stage directly downstream; accepts a stall from, and a PC redirect (branch/jump) back from, execute.

Parameters:
MEM_WORDS, 256, depth of instruction memory in 32-bit words (power of two)
RESET_PC, 32'h00000000, fetch address after reset (word aligned)
NOP_INSTR, 32'h00000013, instruction presented when no valid instruction is held (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall  input  1  hold fetch PC and decode register unchanged this cycle
redirect  input  1  load redirect_pc and squash the held instruction
redirect_pc  input  32  new fetch address; bits [1:0] ignored
fetch_pc  output  32  address being fetched this cycle
pc  output  32  address of the instruction in the decode register
instr  output  32  instruction in the decode register
valid  output  1  decode register holds a real instruction
rs1  output  5  instr[19:15]
rs2  output  5  instr[24:20]
rd  output  5  instr[11:7]
opcode  output  7  instr[6:0]
funct3  output  3  instr[14:12]
funct7  output  7  instr[31:25]
imm  output  32  sign-extended immediate, format chosen by opcode

Behaviour:
- Memory array inst_mem[0:MEM_WORDS-1], 32 bits wide; read-only to the core; contents loaded by the bench via hierarchical write before the first clock. Index = fetch_pc[log2(MEM_WORDS)+1:2]; higher address bits are ignored (wrap modulo memory size).
- Reset (rst=1 at a clock edge, highest priority): fetch_pc<=RESET_PC, pc<=RESET_PC, instr<=NOP_INSTR, valid<=0. Consequently rs1=rs2=rd=0, imm=0, opcode=7'h13. Reset asserted mid-run discards any held instruction and pending stall/redirect.
- Priority per edge: rst > redirect > stall > normal advance.
- Redirect: fetch_pc<={redirect_pc[31:2],2'b00}; instr<=NOP_INSTR, valid<=0 (one-cycle bubble); pc unchanged. Redirect overrides a simultaneous stall.
- Stall (no redirect): fetch_pc, pc, instr, valid all hold.
- Normal advance: instr<=inst_mem[index], pc<=fetch_pc, valid<=1, fetch_pc<=fetch_pc+4 (32-bit wrap: 32'hFFFFFFFC -> 0).
- Latency: instruction at address A appears on instr/fields one edge after fetch_pc==A with no stall/redirect.
- Field outputs are pure combinational slices of instr; no extra cycle.
- imm format by opcode: I (0000011, 0010011, 1100111, 1110011): sext(instr[31:20]); S (0100011): sext({instr[31:25],instr[11:7]}); B (1100011): sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); U (0110111, 0010111): {instr[31:12],12'b0}; J (1101111): sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}); any other opcode: 0.
- No reads of uninitialised memory are defined; the bench must load every word it fetches.

Test Plan:
- Reset: rst=1 one edge -> fetch_pc=0, valid=0, rs1=rs2=rd=0, instr=32'h00000013; after release and one edge with mem[0]=32'h002081B3 -> valid=1, pc=0, rs1=1, rs2=2, rd=3, opcode=7'h33, fetch_pc=4.
- Immediate decode: mem[1]=32'hFFF08293 -> rd=5, rs1=1, imm=32'hFFFFFFFF; mem[2]=32'h0020A423 -> rs1=1, rs2=2, imm=8; mem[3]=32'h12345237 -> rd=4, imm=32'h12345000.
- Stall: assert stall 3 edges while pc=4 -> pc, instr, fetch_pc=8 unchanged all 3 cycles; release -> pc=8 next edge.
- Redirect: redirect=1, redirect_pc=32'h00000013 with stall=1 simultaneously -> next edge fetch_pc=32'h10, valid=0, rd=0; following edge pc=32'h10, valid=1, instr=mem[4].
- Wrap: redirect_pc=4*(MEM_WORDS-1) then advance two edges -> second fetch is mem[0] with pc=4*MEM_WORDS (=32'h400 for default), fetch_pc=32'h404.
- Reset mid-run: rst during a stall with valid=1 -> next edge valid=0, fetch_pc=RESET_PC, stall ignored.
